flash_sample_sequencer: RTL and testbench
=========================================

Name: flash_sample_sequencer

Overview:
Sequences the SPI flash controller to stream 8-bit audio samples to the PWM audio block at a fixed sample rate. It issues start/continue/stop read commands and holds a one-byte prefetch buffer. It plays a programmable address window once or looping, and flags underruns. It sits between the top-level control inputs and the spi_flash_controller / pwm_audio pair.

Parameters:
ADDR_BITS, 24, flash byte address width
SAMPLE_DIV, 1200, clocks per sample (57.6 MHz / 48 kHz)
MIDSCALE, 8'h80, idle/silence sample value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
play  in  1  level; 1 = stream, 0 = stop
loop_en  in  1  sampled at each window end; 1 = restart at start_addr
start_addr  in  ADDR_BITS  first byte of window, sampled on play rise
length  in  ADDR_BITS  window length in bytes, sampled on play rise
spi_start_read  out  1  one-cycle pulse, begin read at spi_addr
spi_continue_read  out  1  one-cycle pulse, fetch next sequential byte
spi_stop_read  out  1  one-cycle pulse, end flash transaction
spi_addr  out  ADDR_BITS  read address, valid with spi_start_read
spi_data  in  8  byte from flash controller
spi_busy  in  1  flash controller fetching
sample  out  8  current sample to PWM
sample_strobe  out  1  one-cycle pulse when sample updates
playing  out  1  high outside IDLE
underrun  out  1  one-cycle pulse, tick with empty buffer

Behaviour:
- Reset: all pulses 0, spi_addr 0, sample = MIDSCALE, playing 0, state IDLE, buffer empty, counters 0.
- States: IDLE, CMD, WAIT, HOLD, DRAIN, STOP.
- IDLE: on play rising (registered previous value) with length != 0: latch start_addr/length, bytes_left = length, spi_start_read = 1, spi_addr = start_addr, tick counter = 0 -> CMD. length == 0: remain IDLE, no pulses.
- CMD: one cycle; spi_busy ignored (controller registers command) -> WAIT.
- WAIT: when spi_busy == 0, next_buf <= spi_data, buf_valid <= 1, bytes_left decrements -> HOLD.
- Tick: counter counts 0..SAMPLE_DIV-1 while playing; tick when counter == SAMPLE_DIV-1, then counter wraps to 0. First tick is SAMPLE_DIV cycles after the play-rise cycle.
- On tick with buf_valid: sample <= next_buf, sample_strobe = 1, buf_valid <= 0, all in the same cycle. On tick without buf_valid: underrun = 1, sample held.
- HOLD, on the consuming tick:
  - bytes_left != 0: spi_continue_read -> CMD.
  - bytes_left == 0 and loop_en: spi_stop_read that cycle, spi_start_read at start_addr next cycle -> CMD; bytes_left reloaded from latched length.
  - bytes_left == 0 and !loop_en: spi_stop_read -> DRAIN.
- A tick in CMD/WAIT (buffer empty) gives underrun; the fetch continues and the byte is played on the next tick.
- DRAIN: last byte already in sample; on the next tick sample <= MIDSCALE with strobe -> IDLE.
- play low in any non-IDLE state: sample <= MIDSCALE with strobe, buf_valid cleared -> STOP. STOP waits for spi_busy == 0, pulses spi_stop_read -> IDLE.
- play rise while in STOP is ignored; play must re-rise from IDLE.
- Command pulses are mutually exclusive in any cycle.

Optional Feature:
FLASH_SEQ_UNDERRUN_CNT_EN
- Defined: adds output underrun_count[15:0]. Increments on every underrun pulse and saturates at 16'hFFFF. Cleared by rst or by the play rising edge.
- Undefined: port absent, no counter logic.

Decomposition:
- Package flash_seq_pkg: state enum typedef, MIDSCALE default, SAMPLE_DIV default.
- One sub-module, sample_tick_gen: SAMPLE_DIV counter with clear input and tick output.
- Everything else lives in the top FSM.

Test Plan:
- length=4, loop_en=0, flash model bytes 11,22,33,44 from addr 0x000100: one start_read at 0x000100, three continue_read. Samples 11,22,33,44 at SAMPLE_DIV spacing, then 0x80, then playing=0.
- length=2, loop_en=1: sequence 11,22,11,22. At each wrap, stop_read followed next cycle by start_read at start_addr.
- Flash model busy lasting SAMPLE_DIV+10 cycles on the second byte: exactly one underrun pulse, sample held, then the byte plays on the following tick.
- play deasserted while spi_busy=1: sample=0x80 with strobe. stop_read issued only after busy falls, then IDLE.
- length=0 with play rising: no command pulses, playing stays 0.
- rst asserted mid-WAIT: next cycle all outputs at reset values, no command pulses. With FLASH_SEQ_UNDERRUN_CNT_EN defined, the counter also reads 0.

Source files
------------

// File: rtl/flash_seq_pkg.sv
// Shared types and defaults for the flash sample sequencer.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_STOP
  } state_e;

  localparam int unsigned ADDR_BITS_DEF  = 24;
  localparam int unsigned SAMPLE_DIV_DEF = 1200;
  localparam logic [7:0]  MIDSCALE_DEF   = 8'h80;

endpackage

// File: rtl/flash_sample_sequencer_tick.sv
// Sample-rate divider: tick_o is high for the cycle in which the counter sits at SAMPLE_DIV-1.
// SAMPLE_DIV must be at least 2.
module sample_tick_gen
  import flash_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered one count early so it lines up with the terminal count
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CW'(SAMPLE_DIV - 1)) cnt_d = '0;
      else                              cnt_d = cnt_q + CW'(1);
      tick_d = (cnt_q == CW'(SAMPLE_DIV - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/flash_sample_sequencer.sv
// Streams bytes from the SPI flash controller to the PWM block at a fixed sample rate.
// Optional underrun_count output is built when FLASH_SEQ_UNDERRUN_CNT_EN is defined.
module flash_sample_sequencer
  import flash_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter logic [7:0]  MIDSCALE   = MIDSCALE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play,
  input  logic                 loop_en,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] length,
  output logic                 spi_start_read,
  output logic                 spi_continue_read,
  output logic                 spi_stop_read,
  output logic [ADDR_BITS-1:0] spi_addr,
  input  logic [7:0]           spi_data,
  input  logic                 spi_busy,
  output logic [7:0]           sample,
  output logic                 sample_strobe,
  output logic                 playing,
  output logic                 underrun
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  state_e               state_q, state_d;
  logic                 play_q;
  logic                 restart_q, restart_d;
  logic [ADDR_BITS-1:0] win_addr_q, win_addr_d;
  logic [ADDR_BITS-1:0] len_q, len_d;
  logic [ADDR_BITS-1:0] left_q, left_d;
  logic [7:0]           buf_q, buf_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [7:0]           sample_q, sample_d;
  logic                 strobe_q, strobe_d;
  logic                 under_q, under_d;
  logic                 start_q, start_d;
  logic                 cont_q, cont_d;
  logic                 stop_q, stop_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 playing_q;

  logic rise_c, begin_c, tick_c;

  assign rise_c  = play && !play_q;
  assign begin_c = (state_q == ST_IDLE) && rise_c && (length != '0);

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear_i(begin_c),
    .en_i   (playing_q),
    .tick_o (tick_c)
  );

  always_comb begin
    state_d     = state_q;
    restart_d   = 1'b0;
    win_addr_d  = win_addr_q;
    len_d       = len_q;
    left_d      = left_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    sample_d    = sample_q;
    strobe_d    = 1'b0;
    under_d     = 1'b0;
    start_d     = 1'b0;
    cont_d      = 1'b0;
    stop_d      = 1'b0;
    addr_d      = addr_q;

    // sample consumption while a fetch is in flight or buffered
    if (tick_c && (state_q == ST_CMD || state_q == ST_WAIT || state_q == ST_HOLD)) begin
      if (buf_valid_q) begin
        sample_d    = buf_q;
        strobe_d    = 1'b1;
        buf_valid_d = 1'b0;
      end else begin
        under_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (begin_c) begin
          win_addr_d = start_addr;
          len_d      = length;
          left_d     = length;
          start_d    = 1'b1;
          addr_d     = start_addr;
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        // loop wrap: stop went out last cycle, restart the window now
        if (restart_q) begin
          start_d = 1'b1;
          addr_d  = win_addr_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!spi_busy) begin
          buf_d       = spi_data;
          buf_valid_d = 1'b1;
          left_d      = left_q - ADDR_BITS'(1);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          if (left_q != '0) begin
            cont_d  = 1'b1;
            state_d = ST_CMD;
          end else if (loop_en) begin
            stop_d    = 1'b1;
            restart_d = 1'b1;
            left_d    = len_q;
            state_d   = ST_CMD;
          end else begin
            stop_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (tick_c) begin
          sample_d = MIDSCALE;
          strobe_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (!spi_busy) begin
          stop_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // play released mid-stream: silence immediately, close the transaction in STOP
    if (!play && state_q != ST_IDLE && state_q != ST_STOP) begin
      sample_d    = MIDSCALE;
      strobe_d    = 1'b1;
      buf_valid_d = 1'b0;
      under_d     = 1'b0;
      start_d     = 1'b0;
      cont_d      = 1'b0;
      stop_d      = 1'b0;
      restart_d   = 1'b0;
      state_d     = ST_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      play_q      <= 1'b0;
      restart_q   <= 1'b0;
      win_addr_q  <= '0;
      len_q       <= '0;
      left_q      <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      sample_q    <= MIDSCALE;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      addr_q      <= '0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      play_q      <= play;
      restart_q   <= restart_d;
      win_addr_q  <= win_addr_d;
      len_q       <= len_d;
      left_q      <= left_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
      start_q     <= start_d;
      cont_q      <= cont_d;
      stop_q      <= stop_d;
      addr_q      <= addr_d;
      playing_q   <= (state_d != ST_IDLE);
    end
  end

  assign spi_start_read    = start_q;
  assign spi_continue_read = cont_q;
  assign spi_stop_read     = stop_q;
  assign spi_addr          = addr_q;
  assign sample            = sample_q;
  assign sample_strobe     = strobe_q;
  assign playing           = playing_q;
  assign underrun          = under_q;

`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // saturating underrun tally, restarted on every play rising edge
  always_comb begin
    ucnt_d = ucnt_q;
    if (rise_c)                              ucnt_d = '0;
    else if (under_d && ucnt_q != 16'hFFFF)  ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Self-checking bench for flash_sample_sequencer: event-table scenarios plus reset sequences.
module tb_flash_sample_sequencer;

  localparam int unsigned AW  = 24;
  localparam int unsigned DIV = 16;

  typedef enum int {EV_START, EV_CONT, EV_STOP, EV_STROBE, EV_UNDER} ev_kind_e;

  typedef struct {
    ev_kind_e        kind;
    int              cyc;
    logic [AW-1:0]   val;
  } ev_t;

  typedef struct {
    int              scen;
    ev_kind_e        kind;
    int              cyc;
    logic [AW-1:0]   val;
  } exp_t;

  typedef struct {
    logic [AW-1:0]   len;
    logic            loop;
    int              slow_idx;
    int              drop;
    int              run;
    int              exp_play;
  } scen_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          play = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] start_addr = 24'h000100;
  logic [AW-1:0] length = '0;
  logic          spi_start_read, spi_continue_read, spi_stop_read;
  logic [AW-1:0] spi_addr;
  logic [7:0]    spi_data;
  logic          spi_busy;
  logic [7:0]    sample;
  logic          sample_strobe, playing, underrun;
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  flash_sample_sequencer #(.ADDR_BITS(AW), .SAMPLE_DIV(DIV), .MIDSCALE(8'h80)) dut (
    .clk              (clk),
    .rst              (rst),
    .play             (play),
    .loop_en          (loop_en),
    .start_addr       (start_addr),
    .length           (length),
    .spi_start_read   (spi_start_read),
    .spi_continue_read(spi_continue_read),
    .spi_stop_read    (spi_stop_read),
    .spi_addr         (spi_addr),
    .spi_data         (spi_data),
    .spi_busy         (spi_busy),
    .sample           (sample),
    .sample_strobe    (sample_strobe),
    .playing          (playing),
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    .underrun_count   (underrun_count),
`endif
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  bit log_en = 1'b0;
  int excl = 0;
  int play_cyc = 0;
  int slow_idx = -1;
  ev_t  evlog[$];
  exp_t exp_tab[$];
  scen_t sc[4];

  always @(posedge clk) cyc <= cyc + 1;

  // flash model: fixed 3-cycle busy per byte, one selectable slow fetch
  logic [AW-1:0] maddr;
  int            mcnt, cmd_n;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - 24'h000100 + 24'd1;
    return 8'(off * 24'd17);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      spi_busy <= 1'b0;
      spi_data <= 8'h00;
      mcnt     <= 0;
      cmd_n    <= 0;
      maddr    <= '0;
    end else if (spi_stop_read) begin
      spi_busy <= 1'b0;
    end else if (spi_start_read || spi_continue_read) begin
      maddr    <= spi_start_read ? spi_addr : maddr + 24'd1;
      spi_busy <= 1'b1;
      mcnt     <= (cmd_n == slow_idx) ? int'(DIV) + 10 : 3;
      cmd_n    <= cmd_n + 1;
    end else if (spi_busy) begin
      if (mcnt == 1) begin
        spi_busy <= 1'b0;
        spi_data <= mem_byte(maddr);
      end
      mcnt <= mcnt - 1;
    end
  end

  // output event recorder, cycle index relative to the play-rise cycle
  always @(negedge clk) begin
    if (log_en) begin
      if (spi_start_read)    evlog.push_back('{EV_START, cyc - t0, spi_addr});
      if (spi_continue_read) evlog.push_back('{EV_CONT, cyc - t0, 24'h0});
      if (spi_stop_read)     evlog.push_back('{EV_STOP, cyc - t0, 24'h0});
      if (sample_strobe)     evlog.push_back('{EV_STROBE, cyc - t0, {16'h0, sample}});
      if (underrun)          evlog.push_back('{EV_UNDER, cyc - t0, 24'h0});
      if (int'(spi_start_read) + int'(spi_continue_read) + int'(spi_stop_read) > 1) excl++;
      if (playing) play_cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " start"}, 32'(spi_start_read), 32'd0);
    chk({tag, " cont"}, 32'(spi_continue_read), 32'd0);
    chk({tag, " stop"}, 32'(spi_stop_read), 32'd0);
    chk({tag, " addr"}, 32'(spi_addr), 32'd0);
    chk({tag, " sample"}, 32'(sample), 32'h80);
    chk({tag, " strobe"}, 32'(sample_strobe), 32'd0);
    chk({tag, " playing"}, 32'(playing), 32'd0);
    chk({tag, " underrun"}, 32'(underrun), 32'd0);
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    chk({tag, " ucount"}, 32'(underrun_count), 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    play = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic void add(input int s, input ev_kind_e k, input int c, input logic [AW-1:0] v);
    exp_tab.push_back('{s, k, c, v});
  endfunction

  initial begin
    sc[0] = '{24'd4, 1'b0, -1, 0, 90, 80};
    sc[1] = '{24'd2, 1'b1, -1, 68, 80, 70};
    sc[2] = '{24'd2, 1'b0, 1, 0, 75, 64};
    sc[3] = '{24'd0, 1'b0, -1, 0, 20, 0};

    add(0, EV_START, 1, 24'h100);  add(0, EV_CONT, 17, 0);  add(0, EV_STROBE, 17, 24'h11);
    add(0, EV_CONT, 33, 0);        add(0, EV_STROBE, 33, 24'h22);
    add(0, EV_CONT, 49, 0);        add(0, EV_STROBE, 49, 24'h33);
    add(0, EV_STOP, 65, 0);        add(0, EV_STROBE, 65, 24'h44);
    add(0, EV_STROBE, 81, 24'h80);

    add(1, EV_START, 1, 24'h100);  add(1, EV_CONT, 17, 0);  add(1, EV_STROBE, 17, 24'h11);
    add(1, EV_STOP, 33, 0);        add(1, EV_STROBE, 33, 24'h22);
    add(1, EV_START, 34, 24'h100);
    add(1, EV_CONT, 49, 0);        add(1, EV_STROBE, 49, 24'h11);
    add(1, EV_STOP, 65, 0);        add(1, EV_STROBE, 65, 24'h22);
    add(1, EV_START, 66, 24'h100);
    add(1, EV_STROBE, 69, 24'h80); add(1, EV_STOP, 71, 0);

    add(2, EV_START, 1, 24'h100);  add(2, EV_CONT, 17, 0);  add(2, EV_STROBE, 17, 24'h11);
    add(2, EV_UNDER, 33, 0);
    add(2, EV_STOP, 49, 0);        add(2, EV_STROBE, 49, 24'h22);
    add(2, EV_STROBE, 65, 24'h80);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");

    for (int s = 0; s < 4; s++) begin
      int j;
      do_reset();
      length   = sc[s].len;
      loop_en  = sc[s].loop;
      slow_idx = sc[s].slow_idx;
      evlog.delete();
      excl = 0;
      play_cyc = 0;
      @(posedge clk); #1;
      play = 1'b1;
      t0 = cyc;
      log_en = 1'b1;
      for (int k = 1; k <= sc[s].run; k++) begin
        @(posedge clk); #1;
        if (k == sc[s].drop) play = 1'b0;
      end
      @(negedge clk);
      log_en = 1'b0;
      j = 0;
      foreach (exp_tab[i]) begin
        if (exp_tab[i].scen == s) begin
          n_vec++;
          if (j >= evlog.size()) begin
            n_err++;
            $display("FAIL s%0d ev%0d: got none expected %s@%0d val 0x%0h", s, j,
                     exp_tab[i].kind.name(), exp_tab[i].cyc, exp_tab[i].val);
          end else if (evlog[j].kind != exp_tab[i].kind || evlog[j].cyc != exp_tab[i].cyc ||
                       evlog[j].val !== exp_tab[i].val) begin
            n_err++;
            $display("FAIL s%0d ev%0d: got %s@%0d val 0x%0h expected %s@%0d val 0x%0h", s, j,
                     evlog[j].kind.name(), evlog[j].cyc, evlog[j].val,
                     exp_tab[i].kind.name(), exp_tab[i].cyc, exp_tab[i].val);
          end
          j++;
        end
      end
      chk($sformatf("s%0d event count", s), 32'(evlog.size()), 32'(j));
      chk($sformatf("s%0d pulse exclusive", s), 32'(excl), 32'd0);
      chk($sformatf("s%0d playing cycles", s), 32'(play_cyc), 32'(sc[s].exp_play));
      chk($sformatf("s%0d end playing", s), 32'(playing), 32'd0);
      chk($sformatf("s%0d end sample", s), 32'(sample), 32'h80);
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
      if (s == 0) chk("s0 ucount", 32'(underrun_count), 32'd0);
      if (s == 2) chk("s2 ucount", 32'(underrun_count), 32'd1);
`endif
    end

    // reset asserted while the first fetch is outstanding
    do_reset();
    length = 24'd4;
    loop_en = 1'b0;
    slow_idx = -1;
    @(posedge clk); #1;
    play = 1'b1;
    t0 = cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre-rst busy", 32'(spi_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    play = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("midwait");
    evlog.delete();
    excl = 0;
    play_cyc = 0;
    log_en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    log_en = 1'b0;
    chk("post-rst events", 32'(evlog.size()), 32'd0);
    chk("post-rst playing", 32'(play_cyc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
